// File: rtl/tagged_table_pkg.sv
// Shared types for the tagged-table SRAM port arbiter.
package tagged_table_pkg;

  localparam int TT_ADDR_W = 9;
  localparam int TT_DATA_W = 12;

  typedef struct packed {
    logic [TT_ADDR_W-1:0] addr;
    logic [TT_DATA_W-1:0] data;
    logic [TT_DATA_W-1:0] mask;
  } tt_wr_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } tt_grant_e;

endpackage

// File: rtl/tagged_table_wq.sv
// Deferred-update write queue with an oldest-to-newest forward merge for lookups.
module tagged_table_wq
  import tagged_table_pkg::*;
#(
  parameter int ADDR_W = TT_ADDR_W,
  parameter int DATA_W = TT_DATA_W,
  parameter int QDEPTH = 4,
  localparam int PTR_W = $clog2(QDEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enq,
  input  logic [ADDR_W-1:0] enq_addr,
  input  logic [DATA_W-1:0] enq_data,
  input  logic [DATA_W-1:0] enq_mask,
  input  logic              deq,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [DATA_W-1:0] head_mask,
  output logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0] fwd_mask
);

  logic [ADDR_W-1:0] addr_q [QDEPTH];
  logic [DATA_W-1:0] data_q [QDEPTH];
  logic [DATA_W-1:0] mask_q [QDEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // Payload storage needs no reset: only slots counted as valid are ever read.
  always_ff @(posedge clock) begin
    if (enq) begin
      addr_q[wr_ptr] <= enq_addr;
      data_q[wr_ptr] <= enq_data;
      mask_q[wr_ptr] <= enq_mask;
    end
  end

  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign head_mask = mask_q[rd_ptr];

  // Walk from the head so newer entries overwrite older ones bit by bit.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_data = '0;
    fwd_mask = '0;
    idx      = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (addr_q[idx] == lookup_addr)) begin
        fwd_data = (fwd_data & ~mask_q[idx]) | (data_q[idx] & mask_q[idx]);
        fwd_mask = fwd_mask | mask_q[idx];
      end
    end
  end

endmodule

// File: rtl/tagged_table_port_arb.sv
// Merges predictor lookups and queued updates onto the single RW port of the
// tagged-table SRAM; reads win unless the queue is full or writes are starved.
module tagged_table_port_arb
  import tagged_table_pkg::*;
#(
  parameter int ADDR_W     = TT_ADDR_W,
  parameter int DATA_W     = TT_DATA_W,
  parameter int QDEPTH     = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] wr_mask,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic [DATA_W-1:0] sram_wmask,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_LIM + 1);

  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] head_mask;
  logic [DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0] fwd_mask;
  logic [DATA_W-1:0] fwd_data_q;
  logic [DATA_W-1:0] fwd_mask_q;
  logic [SC_W-1:0]   starve_cnt;
  logic              q_empty;
  logic              force_wr;
  logic              enq;
  tt_grant_e         grant;

  assign q_empty  = (count == '0);
  assign force_wr = (count == CNT_W'(QDEPTH)) | (starve_cnt == SC_W'(STARVE_LIM));
  assign rd_ready = !force_wr;
  assign wr_ready = (count != CNT_W'(QDEPTH));
  assign enq      = wr_valid & wr_ready;

  tagged_table_wq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .QDEPTH (QDEPTH)
  ) u_wq (
    .clock       (clock),
    .reset_n     (reset_n),
    .enq         (enq),
    .enq_addr    (wr_addr),
    .enq_data    (wr_data),
    .enq_mask    (wr_mask),
    .deq         (grant == WR),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .head_mask   (head_mask),
    .count       (count),
    .lookup_addr (rd_addr),
    .fwd_data    (fwd_data),
    .fwd_mask    (fwd_mask)
  );

  // A starved counter is only reachable with a non-empty queue, but the
  // empty check keeps a forced grant from ever writing a stale head.
  always_comb begin
    grant = IDLE;
    if (force_wr && !q_empty) grant = WR;
    else if (!force_wr && rd_valid) grant = RD;
    else if (!q_empty) grant = WR;
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wmask = '0;
    case (grant)
      RD: begin
        sram_en   = 1'b1;
        sram_addr = rd_addr;
      end
      WR: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = head_addr;
        sram_wdata = head_data;
        sram_wmask = head_mask;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
      rsp_valid  <= 1'b0;
      fwd_data_q <= '0;
      fwd_mask_q <= '0;
    end else begin
      if (grant == WR || q_empty) starve_cnt <= '0;
      else if (grant == RD && starve_cnt != SC_W'(STARVE_LIM)) starve_cnt <= starve_cnt + 1'b1;
      rsp_valid <= (grant == RD);
      if (grant == RD) begin
        fwd_data_q <= fwd_data;
        fwd_mask_q <= fwd_mask;
      end
    end
  end

  assign rsp_data = rsp_valid ? ((sram_rdata & ~fwd_mask_q) | (fwd_data_q & fwd_mask_q)) : '0;

endmodule

// File: doc/tagged_table_port_arb.md
# tagged_table_port_arb

Port arbiter and write queue that directly drives the single-port 512x12 tagged-table SRAM macro wrapper (one shared RW port, per-bit write mask). It merges the predictor's lookup reads and its deferred update writes onto that one port. Reads have priority, writes are buffered, and write starvation is bounded. Read responses forward any pending queued write data, so lookups never see stale entries.

## Interface
- `ADDR_W`, default 9: SRAM index width.
- `DATA_W`, default 12: SRAM word and mask width.
- `QDEPTH`, default 4: write-queue entries; must be a power of 2 and at least 2.
- `STARVE_LIM`, default 8: number of consecutive read grants with a non-empty queue before a write is forced.

Ports:
- `clock` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `rd_valid` in 1: lookup request.
- `rd_ready` out 1: lookup accepted this cycle when `rd_valid & rd_ready`.
- `rd_addr` in ADDR_W: lookup index.
- `rsp_valid` out 1: lookup data valid. No backpressure.
- `rsp_data` out DATA_W: lookup result, with forwarding applied.
- `wr_valid` in 1: update request.
- `wr_ready` out 1: queue can accept.
- `wr_addr` in ADDR_W: update index.
- `wr_data` in DATA_W: update data.
- `wr_mask` in DATA_W: per-bit write enable.
- `sram_en` out 1: SRAM port enable.
- `sram_wmode` out 1: 1 = write, 0 = read.
- `sram_addr` out ADDR_W: SRAM address.
- `sram_wdata` out DATA_W: SRAM write data.
- `sram_wmask` out DATA_W: SRAM write mask.
- `sram_rdata` in DATA_W: SRAM read data, valid the cycle after the read enable.

## Operation
- Write queue: FIFO of {addr, data, mask}.
  - Enqueue on `wr_valid & wr_ready`.
  - `wr_ready = (count != QDEPTH)`, combinational from registered count. A full queue does not pass through a same-cycle dequeue.
- Per-cycle grant:
  - `force_wr = (count == QDEPTH) | (starve_cnt == STARVE_LIM)`.
  - If `force_wr`: issue a write of the queue head, and `rd_ready = 0`.
  - Else if `rd_valid`: issue a read, `rd_ready = 1`.
  - Else if count > 0: issue a write of the head.
  - Else: idle. `sram_en = 0`, and the other SRAM outputs are 0.
- `rd_ready = !force_wr`. It does not depend on `rd_valid`.
- Write issue:
  - `sram_en = 1`, `sram_wmode = 1`.
  - addr, data and mask come from the head entry.
  - The head is dequeued in the same cycle.
- Read issue:
  - `sram_en = 1`, `sram_wmode = 0`, `sram_addr = rd_addr`.
- `starve_cnt` (saturating, width clog2(STARVE_LIM+1)):
  - Increments on a read grant while count > 0.
  - Clears on any write issue, or when count = 0.
- Forwarding, computed at read issue over all valid queue entries, oldest to newest:
  - For each entry with `addr == rd_addr`: `fwd_data = (fwd_data & ~mask) | (data & mask)` and `fwd_mask |= mask`.
  - `fwd_data` and `fwd_mask` are registered alongside the response.
  - `rsp_data = (sram_rdata & ~fwd_mask) | (fwd_data & fwd_mask)`.
  - A write enqueued in the same cycle as a read issue is not visible to that read.
  - The entry being dequeued is never matched, because reads and writes are exclusive in a cycle.
- Counts use `count` width clog2(QDEPTH)+1, with pointers wrapping modulo QDEPTH.
- Simultaneous enqueue and dequeue leaves count unchanged.

## Timing
- Read latency: request accepted in cycle N; `rsp_valid = 1` with data in cycle N+1 only.
- Back-to-back reads give one response per cycle.
- Write: enqueued in N; earliest SRAM write in N+1.
- Worst-case write wait: STARVE_LIM read grants, plus the queue position.
- Reset (async assert, sync release):
  - Queue emptied; count = 0.
  - starve_cnt = 0.
  - `rsp_valid = 0`, `rsp_data = 0`.
  - `sram_en = 0`.
  - `wr_ready = 1`, `rd_ready = 1`.
- Reset mid-operation discards queued writes and any in-flight response. No SRAM write is issued after reset asserts.

## Structure
- Package `tagged_table_pkg`:
  - `ADDR_W`/`DATA_W` defaults.
  - The `tt_wr_entry_t` struct {addr, data, mask}.
  - The `tt_grant_e` enum {IDLE, RD, WR}.
- Sub-module `tagged_table_wq`:
  - Parameterised FIFO.
  - Exposes the head entry, count, and the combinational oldest-to-newest forward merge for a given address.
- The top level holds the grant logic, the starvation counter and the response register.

## Test plan
- Idle queue, read 0x005, `sram_rdata = 0xABC` next cycle -> `rsp_valid` at N+1, `rsp_data = 0xABC`, `sram_wmode = 0`.
- Write addr 0x010, data 0x03F, mask 0x03F, no reads -> next cycle `sram_en = 1`, `wmode = 1`, addr 0x010, wdata 0x03F, wmask 0x03F; count returns to 0.
- One queued write plus continuous `rd_valid` with STARVE_LIM = 8 -> 8 read grants, then `rd_ready = 0` for exactly one cycle while the write issues, then reads resume.
- Enqueue 4 writes while reads are continuous -> `wr_ready = 0` at count 4. The next cycle forces a write and `wr_ready` returns to 1 the cycle after.
- Forwarding: queue holds {0x020, 0xF00, 0xF00} then {0x020, 0x0A0, 0x0F0}; read 0x020 with `sram_rdata = 0x123` -> `rsp_data = 0xFA3`. A read of 0x021 returns raw 0x123.
- Assert `reset_n` low with 3 queued writes and a read in flight -> `rsp_valid` stays 0, no SRAM write issues, and `wr_ready = 1` and count = 0 after release.
